trigger_detect: RTL and testbench

Edge-trigger stage for the scope capture path. It sits directly downstream of sampleIP and consumes `sampled_val` with the averager's `start` strobe as its sample-valid. It compares each new averaged sample against a programmable level with hysteresis and slope, and emits a one-cycle trigger pulse. A holdoff counter then suppresses re-triggering; the capture controller uses the pulse to freeze acquisition.

---
 rtl/scope_pkg.sv | 29 ++
 rtl/trigger_detect_if.sv | 31 +++
 rtl/trigger_detect_sat_addsub.sv | 35 +++
 rtl/trigger_detect.sv | 155 +++++++++++++++
 tb/tb_trigger_detect.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/scope_pkg.sv
// Shared types and constants for the scope trigger path.
package scope_pkg;

    localparam int DEFAULT_W      = 16;
    localparam int DEFAULT_HOLD_W = 16;
    localparam int DEFAULT_CNT_W  = 8;

    localparam logic SLOPE_RISE  = 1'b0;
    localparam logic SLOPE_FALL  = 1'b1;
    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_CONT   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_RESET = 2'd1,
        ST_READY      = 2'd2,
        ST_HOLDOFF    = 2'd3
    } state_t;

    // Where a finished trigger cycle lands: re-qualify in continuous mode, stop otherwise.
    function automatic state_t post_trigger_state(input logic mode);
        if (mode == MODE_CONT) begin
            return ST_WAIT_RESET;
        end else begin
            return ST_IDLE;
        end
    endfunction

endpackage

// File: rtl/trigger_detect_if.sv
// Sample/config/result bundle between the sample source and the trigger stage.
interface trigger_detect_if import scope_pkg::*; #(
    parameter int W      = DEFAULT_W,
    parameter int HOLD_W = DEFAULT_HOLD_W,
    parameter int CNT_W  = DEFAULT_CNT_W
);
    logic [W-1:0]      val;
    logic              val_valid;
    logic [W-1:0]      level;
    logic [W-1:0]      hyst;
    logic              slope;
    logic              mode;
    logic [HOLD_W-1:0] holdoff;
    logic              arm;
    logic              disarm;
    logic              trig;
    logic [W-1:0]      trig_val;
    logic              armed;
    logic [CNT_W-1:0]  trig_count;

    modport master (
        output val, val_valid, level, hyst, slope, mode, holdoff, arm, disarm,
        input  trig, trig_val, armed, trig_count
    );

    modport slave (
        input  val, val_valid, level, hyst, slope, mode, holdoff, arm, disarm,
        output trig, trig_val, armed, trig_count
    );

endinterface

// File: rtl/trigger_detect_sat_addsub.sv
// Saturating level +/- hysteresis: subtract clamps at zero, add clamps at all-ones.
module sat_addsub #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_y
);

    logic [W:0] w_sum;
    logic [W:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Clamp on carry (add) or borrow (subtract).
    always_comb begin
        o_y = {W{1'b0}};
        if (i_sub) begin
            if (w_diff[W]) begin
                o_y = {W{1'b0}};
            end else begin
                o_y = w_diff[W-1:0];
            end
        end else begin
            if (w_sum[W]) begin
                o_y = {W{1'b1}};
            end else begin
                o_y = w_sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/trigger_detect.sv
// Edge trigger with hysteresis re-qualification, holdoff and trigger counting.
module trigger_detect import scope_pkg::*; #(
    parameter int W      = DEFAULT_W,
    parameter int HOLD_W = DEFAULT_HOLD_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    trigger_detect_if.slave  bus
);

    state_t            r_state;
    logic [W-1:0]      r_level;
    logic [W-1:0]      r_hyst;
    logic              r_slope;
    logic              r_mode;
    logic [HOLD_W-1:0] r_holdoff;
    logic [HOLD_W-1:0] r_hcnt;
    logic              r_trig;
    logic [W-1:0]      r_trig_val;
    logic              r_armed;
    logic [CNT_W-1:0]  r_trig_count;

    state_t            w_next;
    logic [HOLD_W-1:0] w_hcnt_next;
    logic              w_trig;
    logic              w_latch;
    logic              w_sub;
    logic [W-1:0]      w_thr;
    logic              w_rearm_ok;
    logic              w_fire_ok;

    // Rising uses lo = level - hyst, falling uses hi = level + hyst.
    assign w_sub = (r_slope == SLOPE_RISE);

    sat_addsub #(.W(W)) u_thr (
        .i_a   (r_level),
        .i_b   (r_hyst),
        .i_sub (w_sub),
        .o_y   (w_thr)
    );

    // Sample comparisons against the latched thresholds.
    always_comb begin
        w_rearm_ok = 1'b0;
        w_fire_ok  = 1'b0;
        if (r_slope == SLOPE_RISE) begin
            w_rearm_ok = (bus.val <= w_thr);
            w_fire_ok  = (bus.val >= r_level);
        end else begin
            w_rearm_ok = (bus.val >= w_thr);
            w_fire_ok  = (bus.val <= r_level);
        end
    end

    // Next-state decode; disarm outranks arm, which outranks sample processing.
    always_comb begin
        w_next      = r_state;
        w_hcnt_next = r_hcnt;
        w_trig      = 1'b0;
        w_latch     = 1'b0;
        if (bus.disarm) begin
            w_next      = ST_IDLE;
            w_hcnt_next = {HOLD_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.arm) begin
                        w_next  = ST_WAIT_RESET;
                        w_latch = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
                ST_WAIT_RESET: begin
                    if (bus.val_valid && w_rearm_ok) begin
                        w_next = ST_READY;
                    end else begin
                        w_next = ST_WAIT_RESET;
                    end
                end
                ST_READY: begin
                    if (bus.val_valid && w_fire_ok) begin
                        w_trig = 1'b1;
                        if (r_holdoff != {HOLD_W{1'b0}}) begin
                            w_next      = ST_HOLDOFF;
                            w_hcnt_next = r_holdoff;
                        end else begin
                            w_next = post_trigger_state(r_mode);
                        end
                    end else begin
                        w_next = ST_READY;
                    end
                end
                ST_HOLDOFF: begin
                    // A count of 0 here is unreachable; treat it like the last sample.
                    if (bus.val_valid) begin
                        if (r_hcnt <= HOLD_W'(1)) begin
                            w_next      = post_trigger_state(r_mode);
                            w_hcnt_next = {HOLD_W{1'b0}};
                        end else begin
                            w_next      = ST_HOLDOFF;
                            w_hcnt_next = r_hcnt - HOLD_W'(1);
                        end
                    end else begin
                        w_next = ST_HOLDOFF;
                    end
                end
                default: begin
                    w_next      = ST_IDLE;
                    w_hcnt_next = {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_level      <= {W{1'b0}};
            r_hyst       <= {W{1'b0}};
            r_slope      <= 1'b0;
            r_mode       <= 1'b0;
            r_holdoff    <= {HOLD_W{1'b0}};
            r_hcnt       <= {HOLD_W{1'b0}};
            r_trig       <= 1'b0;
            r_trig_val   <= {W{1'b0}};
            r_armed      <= 1'b0;
            r_trig_count <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_next;
            r_armed <= (w_next != ST_IDLE);
            r_hcnt  <= w_hcnt_next;
            r_trig  <= w_trig;
            if (w_latch) begin
                r_level   <= bus.level;
                r_hyst    <= bus.hyst;
                r_slope   <= bus.slope;
                r_mode    <= bus.mode;
                r_holdoff <= bus.holdoff;
            end
            if (w_trig) begin
                r_trig_val   <= bus.val;
                r_trig_count <= r_trig_count + CNT_W'(1);
            end
        end
    end

    assign bus.trig       = r_trig;
    assign bus.trig_val   = r_trig_val;
    assign bus.armed      = r_armed;
    assign bus.trig_count = r_trig_count;

endmodule

// File: tb/tb_trigger_detect.sv
// Directed and randomized checks of trigger_detect against a behavioural model.
module tb_trigger_detect;

    localparam int W      = 16;
    localparam int HOLD_W = 16;
    localparam int CNT_W  = 8;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;
    bit   cmp_en;

    trigger_detect_if #(.W(W), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) tif ();

    trigger_detect #(.W(W), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (tif)
    );

    always #5 clk = ~clk;

    // Model: "active" = armed; "primed" = a reset-side sample has been seen;
    // m_skip = samples still to be ignored after a trigger.
    bit m_active, m_primed, m_trig, m_slope, m_mode;
    int m_skip, m_tval, m_cnt, m_level, m_hyst, m_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_primed = 0; m_trig = 0; m_slope = 0; m_mode = 0;
        m_skip = 0; m_tval = 0; m_cnt = 0; m_level = 0; m_hyst = 0; m_hold = 0;
    endtask

    task automatic model_step();
        int v, lo, hi;
        v = int'(tif.val);
        m_trig = 0;
        if (tif.disarm) begin
            m_active = 0;
        end else if (!m_active) begin
            if (tif.arm) begin
                m_active = 1; m_primed = 0; m_skip = 0;
                m_level = int'(tif.level); m_hyst = int'(tif.hyst);
                m_slope = tif.slope; m_mode = tif.mode; m_hold = int'(tif.holdoff);
            end
        end else if (tif.val_valid) begin
            lo = m_level - m_hyst; if (lo < 0) lo = 0;
            hi = m_level + m_hyst; if (hi > 65535) hi = 65535;
            if (m_skip > 0) begin
                m_skip--;
                if (m_skip == 0 && !m_mode) m_active = 0;
            end else if (!m_primed) begin
                if (m_slope ? (v >= hi) : (v <= lo)) m_primed = 1;
            end else if (m_slope ? (v <= m_level) : (v >= m_level)) begin
                m_trig = 1; m_tval = v; m_cnt = (m_cnt + 1) % 256;
                m_primed = 0; m_skip = m_hold;
                if (m_skip == 0 && !m_mode) m_active = 0;
            end
        end
    endtask

    // One clock: model follows the edge, then return at the following negedge.
    task automatic tick();
        @(posedge clk);
        if (rstn) model_step(); else model_reset();
        @(negedge clk);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en && rstn) begin
            chk("cyc_trig", tif.trig, m_trig);
            chk("cyc_trig_val", tif.trig_val, m_tval);
            chk("cyc_armed", tif.armed, m_active);
            chk("cyc_trig_count", tif.trig_count, m_cnt);
        end
    end

    task automatic do_reset();
        rstn = 0; model_reset(); tick(); rstn = 1;
    endtask

    task automatic do_arm(input logic [15:0] lvl, input logic [15:0] hy, input logic sl,
                          input logic md, input logic [15:0] ho);
        tif.level = lvl; tif.hyst = hy; tif.slope = sl; tif.mode = md; tif.holdoff = ho;
        tif.arm = 1; tick(); tif.arm = 0;
    endtask

    task automatic send(input logic [15:0] v);
        tif.val = v; tif.val_valid = 1; tick(); tif.val_valid = 0;
    endtask

    initial begin
        int near;
        clk = 0; rstn = 0; cmp_en = 0; n_checks = 0; n_errors = 0;
        tif.val = 16'hFFFF; tif.val_valid = 0; tif.level = 16'h0; tif.hyst = 16'h0;
        tif.slope = 0; tif.mode = 0; tif.holdoff = 16'h0; tif.arm = 0; tif.disarm = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_trig", tif.trig, 0);
        chk("rst_trig_val", tif.trig_val, 0);
        chk("rst_armed", tif.armed, 0);
        chk("rst_count", tif.trig_count, 0);
        rstn = 1; cmp_en = 1;

        // Rising single-shot
        do_arm(16'h8000, 16'h0100, 1'b0, 1'b0, 16'h0);
        chk("t1_armed", tif.armed, 1);
        send(16'h7000); send(16'h7F00);
        chk("t1_no_early", tif.trig, 0);
        send(16'h8000);
        chk("t1_trig", tif.trig, 1);
        chk("t1_trig_val", tif.trig_val, 16'h8000);
        chk("t1_count", tif.trig_count, 1);
        chk("t1_armed_drop", tif.armed, 0);
        chk("t1_model_cnt", m_cnt, 1);
        tick();
        chk("t1_pulse_end", tif.trig, 0);

        // Already above level at arm: no false fire
        tif.val = 16'hFFFF;
        do_arm(16'h8000, 16'h0100, 1'b0, 1'b0, 16'h0);
        send(16'hFFFF); send(16'hFFFF);
        chk("t2_no_false", tif.trig, 0);
        send(16'h7E00);
        chk("t2_prime_no_trig", tif.trig, 0);
        send(16'h9000);
        chk("t2_trig", tif.trig, 1);
        chk("t2_trig_val", tif.trig_val, 16'h9000);
        chk("t2_count", tif.trig_count, 2);

        // Falling continuous with holdoff 3
        do_reset();
        do_arm(16'h4000, 16'h0100, 1'b1, 1'b1, 16'd3);
        send(16'h5000); send(16'h3000);
        chk("t3_trig1", tif.trig, 1);
        chk("t3_count1", tif.trig_count, 1);
        send(16'h3000);
        chk("t3_hold1", tif.trig, 0);
        send(16'h3000); send(16'h3000);
        chk("t3_hold3", tif.trig, 0);
        send(16'h5000); send(16'h3000);
        chk("t3_trig2", tif.trig, 1);
        chk("t3_count2", tif.trig_count, 2);
        chk("t3_still_armed", tif.armed, 1);
        tif.disarm = 1; tick(); tif.disarm = 0;
        chk("t3_disarmed", tif.armed, 0);

        // Saturation at both ends
        do_arm(16'h0010, 16'h0100, 1'b0, 1'b0, 16'h0);
        send(16'h0005); send(16'h0020);
        chk("t4_lo_sat_nofire", tif.trig, 0);
        send(16'h0000); send(16'h0020);
        chk("t4_lo_sat_fire", tif.trig, 1);
        do_arm(16'hFFF0, 16'h0100, 1'b1, 1'b0, 16'h0);
        send(16'hFFFE); send(16'h0000);
        chk("t4_hi_sat_nofire", tif.trig, 0);
        send(16'hFFFF); send(16'h0000);
        chk("t4_hi_sat_fire", tif.trig, 1);
        chk("t4_hi_trig_val", tif.trig_val, 0);

        // hyst=0, ignored re-arm, disarm beats a qualifying sample, arm+disarm
        do_arm(16'h8000, 16'h0000, 1'b0, 1'b1, 16'h0);
        do_arm(16'h1000, 16'h0000, 1'b1, 1'b0, 16'h0);
        send(16'h7000); send(16'h8000);
        chk("t5_hyst0_fire", tif.trig, 1);
        send(16'h8000);
        tif.disarm = 1; send(16'h8000); tif.disarm = 0;
        chk("t5_disarm_no_trig", tif.trig, 0);
        chk("t5_disarm_idle", tif.armed, 0);
        tif.arm = 1; tif.disarm = 1; tick(); tif.arm = 0; tif.disarm = 0;
        chk("t5_arm_disarm", tif.armed, 0);

        // Async reset during holdoff
        do_arm(16'h8000, 16'h0100, 1'b0, 1'b1, 16'd5);
        send(16'h0000); send(16'h9000);
        chk("t6_trig", tif.trig, 1);
        send(16'h9000);
        #2 rstn = 0; model_reset();
        #1;
        chk("t6_rst_trig_val", tif.trig_val, 0);
        chk("t6_rst_armed", tif.armed, 0);
        chk("t6_rst_count", tif.trig_count, 0);
        @(negedge clk); rstn = 1;
        send(16'h0000); send(16'h9000);
        chk("t6_no_trig_unarmed", tif.trig, 0);
        chk("t6_unarmed", tif.armed, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tif.arm = ($urandom_range(0, 15) == 0);
            tif.disarm = ($urandom_range(0, 59) == 0);
            if (tif.arm) begin
                tif.level = 16'($urandom);
                tif.hyst = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 512));
                tif.slope = 1'($urandom_range(0, 1));
                tif.mode = 1'($urandom_range(0, 1));
                tif.holdoff = 16'($urandom_range(0, 4));
            end
            tif.val_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                tif.val = 16'($urandom);
            end else begin
                near = m_level + $urandom_range(0, 2048) - 1024;
                if (near < 0) near = 0;
                if (near > 65535) near = 65535;
                tif.val = 16'(near);
            end
            if ($urandom_range(0, 499) == 0) begin
                rstn = 0;
                tick();
                rstn = 1;
            end else begin
                tick();
            end
        end
        tif.arm = 0; tif.disarm = 0; tif.val_valid = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
